// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-select/word types and the writeback request payload.
package cpu_types_pkg;

  localparam int unsigned WORD_BITS   = 32;
  localparam int unsigned REGSEL_BITS = 5;
  localparam int unsigned NREGS       = 32;
  localparam int unsigned WB_NREQ     = 2;

  typedef logic [WORD_BITS-1:0]   word_t;
  typedef logic [REGSEL_BITS-1:0] regbits_t;

  typedef struct packed {
    regbits_t wsel;
    word_t    wdat;
  } wb_req_t;

  // One-hot register mask for a destination select.
  function automatic logic [NREGS-1:0] reg_onehot(input regbits_t r);
    reg_onehot = NREGS'(1) << r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, with wrap.
module rr_arbiter #(
  parameter  int unsigned N     = 2,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o
);

  logic found;

  // Pass one covers [ptr, N-1]; pass two wraps to [0, ptr-1].
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req_i[i] && (PTR_W'(i) >= ptr_i)) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters, each with a
// one-entry holding buffer drained round-robin; exports a pending-write mask.
module regfile_wb_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned NREQ   = WB_NREQ,
  parameter int unsigned WORD_W = WORD_BITS,
  parameter int unsigned SEL_W  = REGSEL_BITS
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*SEL_W-1:0]  req_wsel,
  input  logic [NREQ*WORD_W-1:0] req_wdat,
  output logic                   WEN,
  output logic [SEL_W-1:0]       wsel,
  output logic [WORD_W-1:0]      wdat,
  output logic [NREGS-1:0]       pend_mask,
  output logic                   idle
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  full_q, full_d;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  accept;
  wb_req_t          buf_q [NREQ];
  wb_req_t          buf_d [NREQ];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gidx;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i   (full_q),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  // A buffer being drained this cycle can be refilled on the same edge.
  assign req_ready = ~full_q | grant;
  assign accept    = req_valid & req_ready;

  always_comb begin
    gidx  = '0;
    ptr_d = ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) gidx = PTR_W'(i);
    end
    if (|grant) ptr_d = (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);
  end

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      full_d[i] = accept[i] | (full_q[i] & ~grant[i]);
      buf_d[i]  = buf_q[i];
      if (accept[i]) begin
        buf_d[i].wsel = regbits_t'(req_wsel[i*SEL_W +: SEL_W]);
        buf_d[i].wdat = word_t'(req_wdat[i*WORD_W +: WORD_W]);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      full_q <= '0;
      ptr_q  <= '0;
      for (int unsigned i = 0; i < NREQ; i++) buf_q[i] <= '0;
    end else begin
      full_q <= full_d;
      ptr_q  <= ptr_d;
      for (int unsigned i = 0; i < NREQ; i++) buf_q[i] <= buf_d[i];
    end
  end

  // Write port is a pure function of registered buffer state and the grant.
  always_comb begin
    WEN  = |grant;
    wsel = '0;
    wdat = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        wsel = wsel | SEL_W'(buf_q[i].wsel);
        wdat = wdat | WORD_W'(buf_q[i].wdat);
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (full_q[i]) pend_mask = pend_mask | reg_onehot(buf_q[i].wsel);
    end
    pend_mask[0] = 1'b0;
  end

  assign idle = ~|full_q;

`ifndef SYNTHESIS
  // Two requesters must never hold writes to the same nonzero register.
  always @(posedge CLK) begin
    if (nRST) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        for (int unsigned j = i + 1; j < NREQ; j++) begin
          assert (!(full_q[i] && full_q[j] && (buf_q[i].wsel == buf_q[j].wsel) &&
                    (buf_q[i].wsel != '0)))
            else $error("duplicate outstanding write to r%0d", buf_q[i].wsel);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter with a behavioural buffer/round-robin model.
module tb_regfile_wb_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ = 2;
  localparam int SW   = 5;
  localparam int DW   = 32;

  logic                 CLK = 1'b0;
  logic                 nRST;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*SW-1:0]   req_wsel;
  logic [NREQ*DW-1:0]   req_wdat;
  logic                 WEN;
  logic [SW-1:0]        wsel;
  logic [DW-1:0]        wdat;
  logic [31:0]          pend_mask;
  logic                 idle;

  logic [SW-1:0] t_sel [NREQ];
  logic [DW-1:0] t_dat [NREQ];

  int checks   = 0;
  int failures = 0;

  // Model: one slot per requester plus the round-robin start index.
  bit          m_full [NREQ];
  logic [4:0]  m_sel  [NREQ];
  logic [31:0] m_dat  [NREQ];
  int          m_wait [NREQ];
  int          m_ptr;

  regfile_wb_arbiter #(.NREQ(NREQ), .WORD_W(DW), .SEL_W(SW)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wsel  (req_wsel),
    .req_wdat  (req_wdat),
    .WEN       (WEN),
    .wsel      (wsel),
    .wdat      (wdat),
    .pend_mask (pend_mask),
    .idle      (idle)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_wsel[i*SW +: SW] = t_sel[i];
      req_wdat[i*DW +: DW] = t_dat[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_grant();
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (m_full[j]) return j;
    end
    return -1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NREQ; i++) begin
      m_full[i] = 0;
      m_sel[i]  = '0;
      m_dat[i]  = '0;
      m_wait[i] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic check_model();
    int g;
    logic [31:0] e_pend;
    logic [NREQ-1:0] e_rdy;
    bit e_idle;
    g = m_grant();
    e_pend = '0;
    e_idle = 1;
    for (int i = 0; i < NREQ; i++) begin
      if (m_full[i]) begin
        e_idle = 0;
        if (m_sel[i] != 0) e_pend[m_sel[i]] = 1'b1;
      end
      e_rdy[i] = !m_full[i] || (g == i);
    end
    chk("WEN",       {31'd0, WEN}, (g >= 0) ? 32'd1 : 32'd0);
    chk("wsel",      {27'd0, wsel}, (g >= 0) ? {27'd0, m_sel[g]} : 32'd0);
    chk("wdat",      wdat, (g >= 0) ? m_dat[g] : 32'd0);
    chk("pend_mask", pend_mask, e_pend);
    chk("idle",      {31'd0, idle}, {31'd0, e_idle});
    chk("req_ready", {30'd0, req_ready}, {30'd0, e_rdy});
  endtask

  task automatic model_edge();
    int g;
    bit rdy;
    if (!nRST) begin
      m_clear();
      return;
    end
    g = m_grant();
    for (int i = 0; i < NREQ; i++) begin
      rdy = !m_full[i] || (g == i);
      if (g == i) begin
        chk("starvation", {31'd0, m_wait[i] <= NREQ - 1}, 32'd1);
        m_full[i] = 0;
        m_wait[i] = 0;
      end else if (m_full[i]) begin
        m_wait[i]++;
      end
      if (req_valid[i] && rdy) begin
        m_full[i] = 1;
        m_sel[i]  = t_sel[i];
        m_dat[i]  = t_dat[i];
        m_wait[i] = 0;
      end
    end
    if (g >= 0) m_ptr = (g + 1) % NREQ;
    for (int i = 0; i < NREQ; i++)
      for (int j = i + 1; j < NREQ; j++)
        if (m_full[i] && m_full[j])
          chk("hazard_distinct", {31'd0, (m_sel[i] == m_sel[j]) && (m_sel[i] != 0)}, 32'd0);
  endtask

  task automatic cycle();
    @(negedge CLK);
    check_model();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  initial begin
    nRST      = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      t_sel[i] = '0;
      t_dat[i] = '0;
    end
    m_clear();
    @(posedge CLK);
    #1;

    // Reset held two cycles with every requester valid.
    req_valid = '1;
    t_sel[0] = 5'd1;  t_dat[0] = 32'h1111_1111;
    t_sel[1] = 5'd2;  t_dat[1] = 32'h2222_2222;
    cycle();
    cycle();
    chk("rst_WEN",  {31'd0, WEN}, 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_ready", {30'd0, req_ready}, 32'd3);
    nRST = 1'b1;
    req_valid = '0;
    cycle();

    // Single write from requester 0.
    req_valid = 2'b01;
    t_sel[0] = 5'd5; t_dat[0] = 32'hDEADBEEF;
    cycle();
    req_valid = '0;
    chk("single_WEN",  {31'd0, WEN}, 32'd1);
    chk("single_wsel", {27'd0, wsel}, 32'd5);
    chk("single_wdat", wdat, 32'hDEADBEEF);
    chk("single_pend", pend_mask, 32'h20);
    cycle();
    chk("single_done_WEN",  {31'd0, WEN}, 32'd0);
    chk("single_done_idle", {31'd0, idle}, 32'd1);

    // Register 0 write from requester 1 (also returns the pointer to 0).
    req_valid = 2'b10;
    t_sel[1] = 5'd0; t_dat[1] = 32'd1;
    cycle();
    req_valid = '0;
    chk("r0_WEN",  {31'd0, WEN}, 32'd1);
    chk("r0_wsel", {27'd0, wsel}, 32'd0);
    chk("r0_wdat", wdat, 32'd1);
    chk("r0_pend", pend_mask, 32'd0);
    cycle();

    // Contention: both accepted on the same edge.
    req_valid = 2'b11;
    t_sel[0] = 5'd3; t_dat[0] = 32'hA0A0_0003;
    t_sel[1] = 5'd7; t_dat[1] = 32'hB0B0_0007;
    cycle();
    req_valid = '0;
    chk("cont_first",  {27'd0, wsel}, 32'd3);
    chk("cont_pend",   pend_mask, 32'h88);
    cycle();
    chk("cont_second", {27'd0, wsel}, 32'd7);
    chk("cont_pend2",  pend_mask, 32'h80);
    cycle();
    chk("cont_idle",   {31'd0, idle}, 32'd1);

    // Fairness: both streaming; grants alternate starting from requester 0.
    req_valid = 2'b11;
    t_sel[0] = 5'd2; t_sel[1] = 5'd9;
    for (int k = 0; k < 8; k++) begin
      t_dat[0] = 32'h0100 + 32'(k);
      t_dat[1] = 32'h0900 + 32'(k);
      cycle();
      chk("fair_WEN",   {31'd0, WEN}, 32'd1);
      chk("fair_wsel",  {27'd0, wsel}, (k % 2 == 0) ? 32'd2 : 32'd9);
      chk("fair_ready", {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    req_valid = '0;
    cycle();
    cycle();
    cycle();
    chk("fair_idle", {31'd0, idle}, 32'd1);

    // Mid-operation reset discards both buffered writes.
    req_valid = 2'b11;
    t_sel[0] = 5'd4; t_dat[0] = 32'h4444_4444;
    t_sel[1] = 5'd6; t_dat[1] = 32'h6666_6666;
    cycle();
    req_valid = '0;
    nRST = 1'b0;
    cycle();
    nRST = 1'b1;
    chk("midrst_WEN",  {31'd0, WEN}, 32'd0);
    chk("midrst_idle", {31'd0, idle}, 32'd1);
    chk("midrst_pend", pend_mask, 32'd0);
    cycle();
    chk("midrst_gone", {31'd0, WEN}, 32'd0);
    req_valid = 2'b11;
    t_sel[0] = 5'd10; t_dat[0] = 32'hAAAA_000A;
    t_sel[1] = 5'd11; t_dat[1] = 32'hBBBB_000B;
    cycle();
    req_valid = '0;
    chk("midrst_ptr0", {27'd0, wsel}, 32'd10);
    cycle();
    cycle();

    // Random traffic; requesters use disjoint nonzero registers (by parity).
    for (int n = 0; n < 3000; n++) begin
      nRST = ($urandom_range(0, 199) != 0);
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        int r;
        r = int'($urandom_range(0, 15));
        t_sel[i] = (r == 0) ? 5'd0 : 5'((r * NREQ + i) % 32);
        t_dat[i] = $urandom;
      end
      cycle();
    end

    nRST = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 4; k++) cycle();
    chk("final_idle", {31'd0, idle}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
